mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle successor to the single-cycle MIPS control decoder: a state machine sequencing

---
 rtl/mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory ready handshake and wait timeout.
// Optional macro CTRL_BNE_EN enables bne (opcode 000101); otherwise bne decodes as illegal.
module mips_multicycle_ctrl #(
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         state,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_err
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;

  logic is_r, is_jr, is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
  logic tmo_hit;

  logic             req_c, we_c, iord_c, irw_c, pcw_c, rw_c, done_c, ill_c, err_c;
  logic [1:0]       pcs_c, rd_c, m2r_c, asb_c;
  logic [ALUOP_W-1:0] aop_c;

  always_comb begin
    is_r    = (opcode == OP_RTYPE) &&
              (func == 6'b100000 || func == 6'b100100 || func == 6'b100101 ||
               func == 6'b101010 || func == 6'b000000);
    is_jr   = (opcode == OP_RTYPE) && (func == 6'b001000);
    is_addi = (opcode == OP_ADDI);
    is_ori  = (opcode == OP_ORI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
`ifdef CTRL_BNE_EN
    is_bne  = (opcode == OP_BNE);
`else
    is_bne  = 1'b0;
`endif
    legal = is_r | is_jr | is_addi | is_ori | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
  end

  // mem_ready on the final permitted wait cycle takes priority over the abort
  assign tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                   (wait_q == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = FETCH;
    req_c = 1'b0; we_c = 1'b0; iord_c = 1'b0; irw_c = 1'b0; pcw_c = 1'b0;
    rw_c = 1'b0; done_c = 1'b0; ill_c = 1'b0; err_c = 1'b0;
    pcs_c = 2'd0; rd_c = 2'd0; m2r_c = 2'd0; asb_c = 2'd0;
    aop_c = '0;
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        asb_c = 2'd1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = DECODE;
        end else if (tmo_hit) begin
          err_c  = 1'b1;
          done_c = 1'b1;
        end
      end
      DECODE: begin
        if (legal) state_d = EXEC;
        else begin
          ill_c  = 1'b1;
          done_c = 1'b1;
        end
      end
      EXEC: begin
        if (is_r) begin
          aop_c = ALUOP_W'(2'b10);
          state_d = WB;
        end else if (is_addi) begin
          asb_c = 2'd2;
          state_d = WB;
        end else if (is_ori) begin
          asb_c = 2'd3;
          aop_c = ALUOP_W'(2'b11);
          state_d = WB;
        end else if (is_lw || is_sw) begin
          asb_c = 2'd2;
          state_d = MEM;
        end else if (is_beq || is_bne) begin
          aop_c  = ALUOP_W'(2'b01);
          pcw_c  = is_beq ? zero : ~zero;
          pcs_c  = 2'd1;
          done_c = 1'b1;
        end else if (is_j || is_jal) begin
          pcw_c  = 1'b1;
          pcs_c  = 2'd2;
          done_c = 1'b1;
          if (is_jal) begin
            rw_c  = 1'b1;
            rd_c  = 2'd2;
            m2r_c = 2'd2;
          end
        end else if (is_jr) begin
          pcw_c  = 1'b1;
          pcs_c  = 2'd3;
          done_c = 1'b1;
        end
      end
      MEM: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        we_c   = is_sw;
        if (mem_ready) begin
          if (is_lw) state_d = WB;
          else done_c = 1'b1;
        end else if (tmo_hit) begin
          err_c  = 1'b1;
          done_c = 1'b1;
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        rw_c   = 1'b1;
        done_c = 1'b1;
        rd_c   = is_r ? 2'd1 : 2'd0;
        m2r_c  = is_lw ? 2'd1 : 2'd0;
      end
      default: state_d = FETCH;
    endcase
  end

  // Timeout in FETCH keeps the state code, so the counter is cleared explicitly there too
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || tmo_hit) wait_d = '0;
    else if ((state_q == FETCH || state_q == MEM) && !mem_ready && (MEM_TIMEOUT != 0))
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state      = reset ? '0 : state_q;
  assign mem_req    = req_c  & ~reset;
  assign mem_we     = we_c   & ~reset;
  assign iord       = iord_c & ~reset;
  assign ir_write   = irw_c  & ~reset;
  assign pc_write   = pcw_c  & ~reset;
  assign pc_src     = reset ? '0 : pcs_c;
  assign reg_dst    = reset ? '0 : rd_c;
  assign mem_to_reg = reset ? '0 : m2r_c;
  assign alu_src_b  = reset ? '0 : asb_c;
  assign alu_op     = reset ? '0 : aop_c;
  assign reg_write  = rw_c   & ~reset;
  assign instr_done = done_c & ~reset;
  assign illegal_op = ill_c  & ~reset;
  assign mem_err    = err_c  & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues per-cycle expected control vectors, a negedge monitor compares them.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic [2:0] state;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic       reg_write, instr_done, illegal_op, mem_err;

  mips_multicycle_ctrl #(.ALUOP_W(2), .MEM_TIMEOUT(4), .TMO_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;

  // Vector layout: state, req, we, iord, irw, pcw, pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op, rw, done, ill, err
  function automatic logic [21:0] ov(input logic [2:0] st, input logic req, we, io, irw, pcw,
                                     input logic [1:0] pcs, rd, m2r, asb, aop,
                                     input logic rw, done, ill, err);
    return {st, req, we, io, irw, pcw, pcs, rd, m2r, asb, aop, rw, done, ill, err};
  endfunction

  function automatic logic [21:0] f_wait();
    return ov(F, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] f_ok();
    return ov(F, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] dec();
    return ov(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic step(input logic rst, input logic mr, input logic z,
                      input logic [21:0] e, input string nm);
    exp_t x;
    reset = rst; mem_ready = mr; zero = z;
    x.v = e; x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; func = fn;
  endtask

  // Monitor: every cycle with a queued expectation is checked mid-cycle
  initial begin
    logic [21:0] act;
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_dst,
               mem_to_reg, alu_src_b, alu_op, reg_write, instr_done, illegal_op, mem_err};
        checks++;
        if (act !== x.v) begin
          failures++;
          $display("FAIL %s: got %b required %b", x.nm, act, x.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = '0; func = '0;
    @(posedge clk); #1;
    step(1, 1, 0, '0, "reset0");
    step(1, 0, 0, '0, "reset1");

    // add, zero-wait: 4 cycles
    set_ir(6'b000000, 6'b100000);
    step(0, 1, 0, f_ok(), "add_fetch");
    step(0, 1, 0, dec(), "add_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0), "add_exec");
    step(0, 1, 0, ov(W, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0), "add_wb");

    // lw, 3 wait cycles in MEM; ready lands on the timeout boundary cycle and wins
    set_ir(6'b100011, 6'b000000);
    step(0, 1, 0, f_ok(), "lw_fetch");
    step(0, 1, 0, dec(), "lw_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0), "lw_exec");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, ov(M, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_wait");
    step(0, 1, 0, ov(M, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_ready");
    step(0, 1, 0, ov(W, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0), "lw_wb");

    // beq taken then not taken
    set_ir(6'b000100, 6'b000000);
    step(0, 1, 0, f_ok(), "beq1_fetch");
    step(0, 1, 0, dec(), "beq1_dec");
    step(0, 1, 1, ov(E, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0), "beq_taken");
    step(0, 1, 0, f_ok(), "beq2_fetch");
    step(0, 1, 0, dec(), "beq2_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0), "beq_not_taken");

    // jal and jr
    set_ir(6'b000011, 6'b000000);
    step(0, 1, 0, f_ok(), "jal_fetch");
    step(0, 1, 0, dec(), "jal_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0, 1, 1, 0, 0), "jal_exec");
    set_ir(6'b000000, 6'b001000);
    step(0, 1, 0, f_ok(), "jr_fetch");
    step(0, 1, 0, dec(), "jr_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0), "jr_exec");

    // sw zero-wait, ori
    set_ir(6'b101011, 6'b000000);
    step(0, 1, 0, f_ok(), "sw_fetch");
    step(0, 1, 0, dec(), "sw_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0), "sw_exec");
    step(0, 1, 0, ov(M, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sw_mem");
    set_ir(6'b001101, 6'b000000);
    step(0, 1, 0, f_ok(), "ori_fetch");
    step(0, 1, 0, dec(), "ori_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0), "ori_exec");
    step(0, 1, 0, ov(W, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "ori_wb");

    // FETCH timeout on 4th wait cycle, then addi with 3 waits proves counter cleared
    set_ir(6'b001000, 6'b000000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, f_wait(), "tmo_wait");
    step(0, 0, 0, ov(F, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1), "tmo_abort");
    for (int i = 0; i < 3; i++) step(0, 0, 0, f_wait(), "addi_fetch_wait");
    step(0, 1, 0, f_ok(), "addi_fetch");
    step(0, 1, 0, dec(), "addi_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0), "addi_exec");
    step(0, 1, 0, ov(W, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "addi_wb");

    // unsupported R func
    set_ir(6'b000000, 6'b100010);
    step(0, 1, 0, f_ok(), "badfn_fetch");
    step(0, 1, 0, ov(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "badfn_dec");

    // bne
    set_ir(6'b000101, 6'b000000);
    step(0, 1, 0, f_ok(), "bne_fetch");
`ifdef CTRL_BNE_EN
    step(0, 1, 0, dec(), "bne_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0), "bne_taken");
`else
    step(0, 1, 0, ov(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "bne_illegal");
`endif

    // reset during sw MEM wait
    set_ir(6'b101011, 6'b000000);
    step(0, 1, 0, f_ok(), "swr_fetch");
    step(0, 1, 0, dec(), "swr_dec");
    step(0, 1, 0, ov(E, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0), "swr_exec");
    step(0, 0, 0, ov(M, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "swr_mem");
    step(1, 0, 0, '0, "swr_reset");
    step(0, 0, 0, f_wait(), "swr_after_reset");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
